// File: rtl/scanline_irq_gen_if.sv
// scanline_irq_gen_if: CPU write bus (address, data, write strobe) into the interrupt block
interface scanline_irq_gen_if;
  logic [15:0] CPUAD;
  logic [7:0]  CPUWD;
  logic        CPUWE;
  modport master (output CPUAD, CPUWD, CPUWE);
  modport slave  (input  CPUAD, CPUWD, CPUWE);
endinterface

// File: rtl/scanline_irq_gen.sv
// scanline_irq_gen: line-group tick counter raising masked, latched NMI/IRQ channels plus ROM bank register; TICK_SYNC_EN enables the frame-start tick preload
module scanline_irq_gen #(
  parameter int NCH = 3,
  parameter int TICK_W = 9,
  parameter int LINE_SHIFT = 4,
  parameter int PV_W = 9,
  parameter int BANK_W = 3,
  parameter int NMI_CH0 = 1,
  parameter logic [15:0] MASK_ADDR = 16'hE044,
  parameter logic [15:0] ACK_ADDR = 16'hE045,
  parameter logic [15:0] SEL_ADDR = 16'hE048,
  parameter logic [15:0] BANK_ADDR = 16'hF000,
  parameter logic [4*NCH-1:0] SEL_INIT = {4'd4, 4'd3, 4'd0}
) (
  input  logic               CPUCL,
  input  logic               RESET,
  input  logic [PV_W-1:0]    PV,
  scanline_irq_gen_if.slave  bus,
  input  logic [TICK_W-1:0]  SYNC_PRELOAD,
  output logic               cpu_nmi,
  output logic               cpu_irq,
  output logic [BANK_W-1:0]  ROMBK,
  output logic [NCH-1:0]     irq_pend
);
  localparam logic [NCH-1:0] IRQ_SEL = NMI_CH0 != 0 ? ~NCH'(1) : '1;
  logic [TICK_W-1:0] tick, rise;
  logic [15:0]       rise_x;
  logic [PV_W-1:0]   ppv;
  logic [NCH-1:0]    mask, evt, clr;
  logic [3:0]        sel [NCH];
  logic              line_evt, preload_line, mask_wr, ack_wr, bank_wr, unused_bits;
  assign line_evt = (PV != ppv) && (PV[LINE_SHIFT-1:0] == '0);
  assign rise = ~tick & (tick + 1'b1);
  // Indices at or beyond TICK_W land on zero bits of the widened vector
  assign rise_x = 16'(rise);
  assign mask_wr = bus.CPUWE && bus.CPUAD == MASK_ADDR;
  assign ack_wr = bus.CPUWE && bus.CPUAD == ACK_ADDR;
  assign bank_wr = bus.CPUWE && bus.CPUAD == BANK_ADDR;
  assign clr = (ack_wr ? bus.CPUWD[NCH-1:0] : '0) | (mask_wr ? ~bus.CPUWD[NCH-1:0] : '0);
  assign unused_bits = ^{bus.CPUWD, SYNC_PRELOAD};
`ifdef TICK_SYNC_EN
  logic sync;
  assign preload_line = line_evt && sync && PV == '0;
`else
  assign preload_line = 1'b0;
`endif
  always_comb begin
    evt = '0;
    for (int i = 0; i < NCH; i++)
      evt[i] = line_evt && !preload_line && mask[i] && int'(sel[i]) < TICK_W && rise_x[sel[i]];
  end
  assign cpu_nmi = NMI_CH0 != 0 ? irq_pend[0] : 1'b0;
  assign cpu_irq = |(irq_pend & IRQ_SEL);
  always_ff @(negedge CPUCL) begin
    if (RESET) begin
      tick <= '0;
      mask <= '0;
      irq_pend <= '0;
      ROMBK <= '0;
      ppv <= '1;
      for (int i = 0; i < NCH; i++) sel[i] <= SEL_INIT[4*i +: 4];
`ifdef TICK_SYNC_EN
      sync <= 1'b1;
`endif
    end else begin
      ppv <= PV;
      tick <= preload_line ? SYNC_PRELOAD : line_evt ? tick + 1'b1 : tick;
`ifdef TICK_SYNC_EN
      if (preload_line) sync <= 1'b0;
`endif
      // A new event outranks a same-edge clear so no interrupt is dropped
      irq_pend <= (irq_pend & ~clr) | evt;
      if (mask_wr) mask <= bus.CPUWD[NCH-1:0];
      for (int i = 0; i < NCH; i++)
        if (bus.CPUWE && bus.CPUAD == 16'(SEL_ADDR + i)) sel[i] <= bus.CPUWD[3:0];
      if (bank_wr) ROMBK <= bus.CPUWD[7:8-BANK_W];
    end
  end
endmodule

// File: tb/tb_scanline_irq_gen.sv
// tb_scanline_irq_gen: directed stimulus with an arithmetic reference model compared every cycle
module tb_scanline_irq_gen;
  localparam logic [15:0] MASK_A = 16'hE044, ACK_A = 16'hE045, SEL_A = 16'hE048, BANK_A = 16'hF000;
  logic clk = 1'b0;
  logic rst;
  logic [8:0] pv;
  logic [8:0] pre;
  logic nmi, irq;
  logic [2:0] rombk, pend;
  int tests = 0, fails = 0;
  logic chk_en = 1'b0;
  int m_tick, m_ppv, m_sel [3];
  logic [2:0] m_pend, m_mask, m_bank;
  logic m_sync;
  scanline_irq_gen_if bus ();
  scanline_irq_gen dut (
    .CPUCL(clk), .RESET(rst), .PV(pv), .bus(bus), .SYNC_PRELOAD(pre),
    .cpu_nmi(nmi), .cpu_irq(irq), .ROMBK(rombk), .irq_pend(pend)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // Reference: tick as an integer; bit s of the counter rises on t->t+1 exactly when (t+1) mod 2^(s+1) == 2^s
  always @(negedge clk) begin
    logic le, pl;
    logic [2:0] ev, cl;
    int s;
    if (rst) begin
      m_tick <= 0; m_mask <= 0; m_pend <= 0; m_bank <= 0; m_ppv <= 511; m_sync <= 1'b1;
      m_sel[0] <= 0; m_sel[1] <= 3; m_sel[2] <= 4;
    end else begin
      le = (int'(pv) != m_ppv) && (pv % 16 == 0);
`ifdef TICK_SYNC_EN
      pl = le && m_sync && pv == 0;
`else
      pl = 1'b0;
`endif
      ev = '0;
      for (int j = 0; j < 3; j++) begin
        s = m_sel[j];
        if (le && !pl && m_mask[j] && s < 9 && ((m_tick + 1) % (1 << (s + 1))) == (1 << s)) ev[j] = 1'b1;
      end
      cl = '0;
      if (bus.CPUWE && bus.CPUAD == ACK_A) cl = cl | bus.CPUWD[2:0];
      if (bus.CPUWE && bus.CPUAD == MASK_A) begin
        cl = cl | ~bus.CPUWD[2:0];
        m_mask <= bus.CPUWD[2:0];
      end
      for (int j = 0; j < 3; j++)
        if (bus.CPUWE && bus.CPUAD == SEL_A + 16'(j)) m_sel[j] <= int'(bus.CPUWD[3:0]);
      if (bus.CPUWE && bus.CPUAD == BANK_A) m_bank <= bus.CPUWD[7:5];
      m_pend <= (m_pend & ~cl) | ev;
      m_tick <= pl ? int'(pre) : le ? (m_tick + 1) % 512 : m_tick;
      if (pl) m_sync <= 1'b0;
      m_ppv <= int'(pv);
    end
  end
  always @(posedge clk) begin
    if (chk_en) begin
      check("model_pend", 32'(pend), 32'(m_pend));
      check("model_nmi", 32'(nmi), 32'(m_pend[0]));
      check("model_irq", 32'(irq), 32'(|m_pend[2:1]));
      check("model_rombk", 32'(rombk), 32'(m_bank));
    end
  end
  task automatic cyc(input int p);
    pv = p[8:0];
    bus.CPUWE = 1'b0;
    @(posedge clk);
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.CPUAD = a;
    bus.CPUWD = d;
    bus.CPUWE = 1'b1;
    @(posedge clk);
    bus.CPUWE = 1'b0;
  endtask
  task automatic toggle();
    cyc(pv == 0 ? 16 : 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; pv = 9'd8; pre = 9'd48;
    bus.CPUAD = '0; bus.CPUWD = '0; bus.CPUWE = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    check("reset_pend", 32'(pend), 0);
    check("reset_nmi", 32'(nmi), 0);
    check("reset_irq", 32'(irq), 0);
    check("reset_rombk", 32'(rombk), 0);
    wr(MASK_A, 8'h01);
    for (int p = 9; p < 16; p++) cyc(p);
    check("sweep_nmi_before16", 32'(nmi), 0);
    cyc(16);
    check("sweep_nmi_at16", 32'(nmi), 1);
    check("sweep_irq_at16", 32'(irq), 0);
    wr(MASK_A, 8'h02);
    check("maskwr_clears_nmi", 32'(nmi), 0);
    repeat (6) toggle();
    check("tick7_no_evt", 32'(pend), 0);
    toggle();
    check("tick8_pend", 32'(pend), 32'h2);
    check("tick8_irq", 32'(irq), 1);
    wr(ACK_A, 8'h02);
    check("ack_irq", 32'(irq), 0);
    wr(SEL_A + 16'd1, 8'h00);
    pv = 9'd16;
    wr(MASK_A, 8'h00);
    check("set_wins", 32'(pend), 32'h2);
    wr(ACK_A, 8'h02);
    check("set_wins_ack", 32'(pend), 0);
    wr(BANK_A, 8'hA0);
    check("bank_a0", 32'(rombk), 32'h5);
    wr(16'hF001, 8'hFF);
    check("bank_unmapped", 32'(rombk), 32'h5);
    wr(MASK_A, 8'h01);
    cyc(0);
    cyc(16);
    check("pre_reset_nmi", 32'(nmi), 1);
    rst = 1'b1; pv = 9'd8;
    @(posedge clk);
    rst = 1'b0;
    check("midreset_rombk", 32'(rombk), 0);
    check("midreset_pend", 32'(pend), 0);
    check("midreset_nmi", 32'(nmi), 0);
    check("midreset_irq", 32'(irq), 0);
`ifdef TICK_SYNC_EN
    wr(MASK_A, 8'h01);
    cyc(0);
    check("preload_no_evt", 32'(pend), 0);
    cyc(16);
    check("preload_49_nmi", 32'(nmi), 1);
    wr(ACK_A, 8'h01);
    cyc(0);
    check("second_frame_50", 32'(pend), 0);
    cyc(16);
    check("second_frame_51", 32'(nmi), 1);
    wr(ACK_A, 8'h01);
`endif
    wr(MASK_A, 8'h07);
    for (int k = 0; k < 600 && m_tick != 511; k++) toggle();
    check("wrap_reached", 32'(m_tick), 511);
    wr(ACK_A, 8'h07);
    check("wrap_ack", 32'(pend), 0);
    toggle();
    check("wrap_511_to_0", 32'(pend), 0);
    toggle();
    check("wrap_0_to_1", 32'(pend), 32'h1);
    wr(SEL_A + 16'd2, 8'h09);
    wr(ACK_A, 8'h07);
    repeat (20) toggle();
    check("sel_out_of_range", 32'(pend[2]), 0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
